// File: rtl/fifo_sync_level.sv
// Single-clock FIFO with fill level, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a synchronous flush.
// Optional build macro FIFO_FWFT_EN: rd_data shows the head word combinationally
// (first-word-fall-through); otherwise rd_data is a registered pop result.
module fifo_sync_level #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_SIZE     = 4,
  parameter int unsigned AFULL_THRESH  = 12,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrt_ena,
  input  logic [DATA_WIDTH-1:0] wrt_data,
  output logic                  wrt_full,
  output logic                  wrt_almost_full,
  output logic                  wrt_overflow,
  input  logic                  rd_ena,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic                  rd_underflow,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic [ADDR_SIZE:0]    level
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;
  localparam int unsigned PW    = ADDR_SIZE + 1;

  localparam logic [ADDR_SIZE:0] DepthLvl  = PW'(DEPTH);
  localparam logic [ADDR_SIZE:0] AfullLvl  = PW'(AFULL_THRESH);
  localparam logic [ADDR_SIZE:0] AemptyLvl = PW'(AEMPTY_THRESH);

  logic [ADDR_SIZE:0]    wptr_q, wptr_d;
  logic [ADDR_SIZE:0]    rptr_q, rptr_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Pointers carry one extra wrap bit, so the difference is the exact occupancy.
  assign level           = wptr_q - rptr_q;
  assign wrt_full        = (level == DepthLvl);
  assign rd_empty        = (level == '0);
  assign wrt_almost_full = (level >= AfullLvl);
  assign rd_almost_empty = (level <= AemptyLvl);
  assign wrt_overflow    = overflow_q;
  assign rd_underflow    = underflow_q;

  // Flush overrides any transfer in the same cycle; no bypass when full.
  assign wr_acc = wrt_ena & ~wrt_full & ~flush;
  assign rd_acc = rd_ena & ~rd_empty & ~flush;

  // Next-state for pointers and sticky error flags (set beats clear).
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    if (wrt_ena && wrt_full) overflow_d = 1'b1;
    if (rd_ena && rd_empty) underflow_d = 1'b1;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
    end
  end

  // Pointer and error-flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q[ADDR_SIZE-1:0]] <= wrt_data;
  end

`ifdef FIFO_FWFT_EN
  // Head word is visible whenever the FIFO holds data; rd_ena only acknowledges.
  assign rd_data = mem_q[rptr_q[ADDR_SIZE-1:0]];
`else
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Registered read: capture the head word on the accepting edge, else hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else if (rd_acc) begin
      rd_data_q <= mem_q[rptr_q[ADDR_SIZE-1:0]];
    end
  end

  assign rd_data = rd_data_q;
`endif

endmodule
